// File: rtl/bitserial_alu_ctrl_if.sv
// Host and ALU-slice signal bundle for bitserial_alu_ctrl.
// The abort input exists only when BSALU_ABORT_EN is defined.
interface bitserial_alu_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
`ifdef BSALU_ABORT_EN
  logic             abort;
`endif
  logic             alu_a;
  logic             alu_b;
  logic             alu_ainvert;
  logic             alu_binvert;
  logic             alu_carryin;
  logic [1:0]       alu_op;
  logic             alu_result;
  logic             alu_cout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             overflow;
  logic             err;

  // master: host plus the 1-bit slice; slave: the sequencer
  modport master (
`ifdef BSALU_ABORT_EN
    output abort,
`endif
    output start, op_sel, a_in, b_in, alu_result, alu_cout,
    input  alu_a, alu_b, alu_ainvert, alu_binvert, alu_carryin, alu_op,
    input  busy, done, result, cout, zero, overflow, err
  );

  modport slave (
`ifdef BSALU_ABORT_EN
    input  abort,
`endif
    input  start, op_sel, a_in, b_in, alu_result, alu_cout,
    output alu_a, alu_b, alu_ainvert, alu_binvert, alu_carryin, alu_op,
    output busy, done, result, cout, zero, overflow, err
  );
endinterface

// File: rtl/bitserial_alu_ctrl.sv
// Bit-serial ALU sequencer: feeds an external 1-bit ALU slice LSB first and assembles the result.
// Optional abort input enabled by defining BSALU_ABORT_EN.
module bitserial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  bitserial_alu_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // state | meaning
  // IDLE  | waiting for start, slice outputs held at 0
  // RUN   | one operand bit per cycle through the slice
  // DONE  | result complete, done pulses on exit
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [3:0]       ctrl_q;
  logic             arith_q, carry_q;
  logic             busy_q, done_q, cout_q, zero_q, ovf_q, err_q;

  logic [3:0] ctrl_d;
  logic       legal_d, sub_d, arith_d, zero_d, abort_w;

  // ctrl = {ainvert, binvert, alu_op[1:0]}
  always_comb begin
    ctrl_d  = 4'b0000;
    legal_d = 1'b1;
    case (bus.op_sel)
      3'b000:  ctrl_d = 4'b0000;
      3'b001:  ctrl_d = 4'b0001;
      3'b010:  ctrl_d = 4'b0010;
      3'b011:  ctrl_d = 4'b0110;
      3'b100:  ctrl_d = 4'b1100;
      3'b101:  ctrl_d = 4'b1101;
      default: legal_d = 1'b0;
    endcase
  end

  assign sub_d   = (bus.op_sel == 3'b011);
  assign arith_d = (bus.op_sel == 3'b010) || sub_d;
  assign zero_d  = ~err_q & (result_q == '0);

`ifdef BSALU_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ctrl_q   <= '0;
      arith_q  <= 1'b0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.a_in;
            b_q      <= bus.b_in;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ctrl_q   <= ctrl_d;
            arith_q  <= arith_d;
            carry_q  <= sub_d;
            if (legal_d) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              err_q   <= 1'b0;
            end else begin
              state_q <= DONE;
              err_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort_w) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
          end else begin
            result_q[cnt_q] <= bus.alu_result;
            carry_q         <= bus.alu_cout;
            cnt_q           <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
              // carry_q still holds the carry into the MSB here
              cout_q  <= arith_q & bus.alu_cout;
              ovf_q   <= arith_q & (carry_q ^ bus.alu_cout);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          zero_q  <= zero_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_a       = busy_q & a_q[cnt_q];
  assign bus.alu_b       = busy_q & b_q[cnt_q];
  assign bus.alu_ainvert = busy_q & ctrl_q[3];
  assign bus.alu_binvert = busy_q & ctrl_q[2];
  assign bus.alu_op      = busy_q ? ctrl_q[1:0] : 2'b00;
  assign bus.alu_carryin = busy_q & carry_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.cout        = cout_q;
  assign bus.zero        = zero_q;
  assign bus.overflow    = ovf_q;
  assign bus.err         = err_q;
endmodule

// File: doc/bitserial_alu_ctrl.md
BITSERIAL_ALU_CTRL -- requirements
Module: bitserial_alu_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin one operation; sampled in IDLE only.
REQ-005 Port: op_sel  input  3  operation: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 NOR, 101 NAND; 110/111 illegal.
REQ-006 Port: a_in, b_in  input  WIDTH  operands, captured on accepted start.
REQ-007 Port: alu_a, alu_b, alu_ainvert, alu_binvert, alu_carryin  output  1 each  drive to the external 1-bit ALU slice.
REQ-008 Port: alu_op  output  2  slice operation select (00 AND, 01 OR, 10 SUM).
REQ-009 Port: alu_result, alu_cout  input  1 each  combinational slice outputs.
REQ-010 Port: busy  output  1  high while in RUN.
REQ-011 Port: done  output  1  one-cycle pulse when the result is valid.
REQ-012 Port: result  output  WIDTH  assembled result, held until the next accepted start.
REQ-013 Port: cout, zero, overflow, err  output  1 each  status flags, held with result.

Function
REQ-014 FSM states: IDLE, RUN, DONE; transitions: IDLE->RUN on start with legal op_sel; IDLE->DONE on start with illegal op_sel; RUN->DONE after bit WIDTH-1; DONE->IDLE unconditionally.
REQ-015 Accepted start captures a_in, b_in and op_sel, clears the bit counter to 0, clears result to 0, and clears err.
REQ-016 In RUN the block processes bit i = counter, LSB first, one bit per cycle, and drives alu_a = a_reg[i] and alu_b = b_reg[i].
REQ-017 Slice controls per op (ainvert, binvert, alu_op): AND 0,0,00; OR 0,0,01; ADD 0,0,10; SUB 0,1,10; NOR 1,1,00; NAND 1,1,01.
REQ-018 alu_carryin on bit 0 is 1 for SUB and 0 for all other ops.
REQ-019 alu_carryin on bits 1..WIDTH-1 is the internal carry register, which loads alu_cout each RUN cycle.
REQ-020 alu_result is written into result[i] on the rising edge ending the bit-i cycle.
REQ-021 Latency: start sampled at edge 0 -> busy high edges 1..WIDTH -> done high for exactly the cycle after edge WIDTH+1.
REQ-022 Illegal op: done pulses on the cycle after the start edge, err=1, result=0, and cout/zero/overflow=0.
REQ-023 cout is the alu_cout of bit WIDTH-1 for ADD/SUB and 0 for logical ops.
REQ-024 overflow = (carry into MSB XOR carry out of MSB) for ADD/SUB, and 0 for logical ops.
REQ-025 zero = (result == 0); it is updated together with done and held afterwards.
REQ-026 start while busy or in DONE is ignored, and the operation in flight continues unaffected.
REQ-027 In IDLE/DONE, all alu_* outputs are driven to 0.

Reset
REQ-028 rst_n low forces, without a clock edge, state=IDLE, counter=0, carry=0, result=0, and busy/done/cout/zero/overflow/err=0.
REQ-029 Reset asserted mid-RUN discards the operation; no done pulse follows reset release.

Configuration
REQ-030 Macro BSALU_ABORT_EN, when defined, adds the input port abort (1 bit).
REQ-031 With BSALU_ABORT_EN, abort high in RUN returns to IDLE on the next edge with no done pulse, and result/flags revert to 0.
REQ-032 With BSALU_ABORT_EN, abort is ignored outside RUN.
REQ-033 Without BSALU_ABORT_EN, the abort port does not exist and RUN always completes all WIDTH bits.

Verification (WIDTH=8, bench drives the team's 1-bit ALU slice)
REQ-034 ADD a=8'h7F b=8'h01 -> result 8'h80, cout 0, overflow 1, zero 0, done 9 cycles after the start edge.
REQ-035 SUB a=8'h05 b=8'h05 -> result 8'h00, zero 1, cout 1, overflow 0; SUB 8'h00-8'h01 -> 8'hFF, cout 0.
REQ-036 NAND 8'hFF,8'hFF -> 8'h00 zero 1; NOR 8'h00,8'h00 -> 8'hFF; AND 8'hF0,8'h3C -> 8'h30; OR 8'hF0,8'h0F -> 8'hFF.
REQ-037 op_sel 3'b111 -> err 1, result 8'h00, done pulse 1 cycle after start; second start during busy -> ignored, first result intact.
REQ-038 rst_n low during bit 3 of ADD -> busy/result immediately 0, no done after release; with BSALU_ABORT_EN, abort at bit 4 -> IDLE, no done.
